candidate_checker: RTL
======================

Name: candidate_checker

Overview:
- Initiator-side client of the 81-cell board store's single read/write port.
- Given a target cell and a candidate digit, it reads all 27 row, column and box peer positions through the store's port, one read per cycle and pipelined.
- It reports whether the candidate is legal, plus the first conflicting peer.
- The solver FSM uses it for every placement decision.
- While busy, it owns the store's cell_index/read_en lines; the solver muxes them.

Parameters:
- CELLS, 81, number of board cells (fixed 9x9; not meant to be overridden)
- DIGIT_W, 4, width of a cell value

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset; asynchronous and active-low (asserted at 0)
- start  input  1  request pulse; sampled only in IDLE
- target_index  input  7  cell under test, 0..80, row-major (row*9+col)
- candidate  input  4  digit to test, 1..9
- mem_read_en  output  1  read strobe to board store
- mem_write_en  output  1  constant 0; checker never writes
- mem_cell_index  output  7  peer address presented to store
- mem_data_out  input  4  store read data; registered, valid the cycle after the address
- busy  output  1  high from the cycle after start through the DONE cycle
- done  output  1  single-cycle completion pulse
- valid  output  1  candidate legal; meaningful when done=1
- err  output  1  illegal request (candidate 0 or >9, or target_index>80)
- conflict_index  output  7  first conflicting peer in scan order; 7'd127 if none

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0, except conflict_index=127. Latched target/candidate=0.
- IDLE: mem_read_en=0, mem_cell_index=0.
  - On edge E0 with start=1, latch target_index and candidate.
  - Input check at E0: if candidate==0, candidate>9 or target_index>80, go to DONE with err=1, valid=0. done is high E0..E1.
  - Otherwise go to SCAN with k=0 and clear the conflict flag.
- SCAN, 27 cycles, k=0..26, one per cycle:
  - mem_read_en=1, mem_cell_index=peer(k).
  - r=target/9, c=target%9.
  - k 0..8: r*9+k.
  - k 9..17: (k-9)*9+c.
  - k 18..26: (r/3)*27+(c/3)*3+((k-18)/3)*9+(k-18)%3.
  - After k=26, go to DRAIN.
- Compare pipeline:
  - The address for peer k is presented during cycle E_k..E_{k+1}. The store captures it at E_{k+1}.
  - The tag (peer index plus a self-mask bit) is delayed one cycle. mem_data_out is compared at E_{k+2}.
  - A hit is mem_data_out==candidate AND peer!=target. On the first hit, set the conflict flag and latch conflict_index. Later hits do not overwrite it.
- DRAIN, 1 cycle (E27..E28): mem_read_en=0. The final compare registers at E28.
- DONE, 1 cycle (E28..E29): done=1, valid=~conflict, err=0. Then return to IDLE.
- Total latency: done is high 28 cycles after the start edge.
- Result hold: valid, err and conflict_index hold until the next accepted start. busy=0 in IDLE.
- start while busy is ignored, not queued.
- A 0 (empty) peer never matches, because candidate≥1.
- The target cell's own value is ignored; it appears 3 times in the scan and is masked each time.
- Duplicate peer positions (row∩box, col∩box) are re-read harmlessly. Only the first hit is reported.
- Reset mid-scan: immediate return to IDLE. No done pulse. mem_read_en drops asynchronously.
- start and rst deasserting in the same cycle: start is not accepted until the first edge with rst=1.

Decomposition:
- Package sudoku_pkg holds:
  - constants: BOARD_DIM=9, BOX_DIM=3, CELLS=81, NO_CONFLICT=7'd127, PEER_COUNT=27
  - state enum {IDLE, SCAN, DRAIN, DONE}
  - function peer_index(target, k)
- Sub-module peer_addr_gen: combinational target+k → peer index, including the /9 and %9 split via a 81-entry lookup. It is reused by the future solver's candidate-mask builder.

Test Plan:
- Empty board (all zeros), target=40, candidate=5 → done exactly 28 cycles after start; valid=1; conflict_index=127; exactly 27 read_en cycles.
- Board with cell 36 (row 4)=7, target=40, candidate=7 → valid=0, conflict_index=36. Same board, candidate=6 → valid=1.
- Cell 80=3 and cell 0=3, target=8, candidate=3 → conflict_index=0. Row scan precedes column scan.
- Target cell itself =9, all others 0, target=10, candidate=9 → valid=1 (self masked).
- candidate=0, then candidate=10, then target_index=81 → each gives done one cycle after start, err=1, valid=0, no read_en.
- Assert rst at scan cycle 12 → busy, done, mem_read_en go 0 immediately. A new start after release completes normally in 28 cycles. start pulsed during a scan is ignored (single done pulse).

Source files
------------

// File: rtl/sudoku_pkg.sv
// Shared board geometry, checker state encoding and a reference peer-address function.
package sudoku_pkg;

  localparam int BOARD_DIM  = 9;
  localparam int BOX_DIM    = 3;
  localparam int CELLS      = 81;
  localparam int PEER_COUNT = 27;
  localparam int DIGIT_W    = 4;

  localparam logic [6:0] NO_CONFLICT = 7'd127;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_e;

  // Scan order: row peers (k 0..8), column peers (k 9..17), box peers (k 18..26).
  function automatic logic [6:0] peer_index(input logic [6:0] target, input logic [4:0] k);
    logic [6:0] r;
    logic [6:0] c;
    logic [6:0] kb;
    r  = target / 7'd9;
    c  = target % 7'd9;
    kb = 7'(k) - 7'd18;
    if (k < 5'd9)
      peer_index = r * 7'd9 + 7'(k);
    else if (k < 5'd18)
      peer_index = (7'(k) - 7'd9) * 7'd9 + c;
    else
      peer_index = (r / 7'd3) * 7'd27 + (c / 7'd3) * 7'd3 + (kb / 7'd3) * 7'd9 + (kb % 7'd3);
  endfunction

endpackage

// File: rtl/peer_addr_gen.sv
// Combinational peer address for (target, k); row/col split comes from an 81-entry lookup
// rather than a divider so the same block can serve the solver's candidate-mask builder.
module peer_addr_gen
  import sudoku_pkg::*;
(
  input  logic [6:0] target,
  input  logic [4:0] k,
  output logic [6:0] peer
);

  logic [3:0] row;
  logic [3:0] col;
  logic [4:0] kb;

  always_comb begin
    row = '0;
    col = '0;
    for (int i = 0; i < CELLS; i++) begin
      if (target == 7'(i)) begin
        row = 4'(i / BOARD_DIM);
        col = 4'(i % BOARD_DIM);
      end
    end
  end

  always_comb begin
    kb   = k - 5'd18;
    peer = '0;
    if (k < 5'd9)
      peer = 7'(row) * 7'd9 + 7'(k);
    else if (k < 5'd18)
      peer = (7'(k) - 7'd9) * 7'd9 + 7'(col);
    else
      peer = 7'(row / 4'd3) * 7'd27 + 7'(col / 4'd3) * 7'd3
           + 7'(kb / 5'd3) * 7'd9 + 7'(kb % 5'd3);
  end

endmodule

// File: rtl/candidate_checker.sv
// Scans the 27 peers of a cell through the board store and reports legality plus first conflict.
// Latency: done 28 cycles after the accepted start edge (same edge on err); start ignored while busy.
module candidate_checker
  import sudoku_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [6:0]         target_index,
  input  logic [DIGIT_W-1:0] candidate,
  output logic               mem_read_en,
  output logic               mem_write_en,
  output logic [6:0]         mem_cell_index,
  input  logic [DIGIT_W-1:0] mem_data_out,
  output logic               busy,
  output logic               done,
  output logic               valid,
  output logic               err,
  output logic [6:0]         conflict_index
);

  chk_state_e         state_q, state_d;
  logic [4:0]         k_q, k_d;
  logic [6:0]         target_q, target_d;
  logic [DIGIT_W-1:0] cand_q, cand_d;
  logic               conflict_q, conflict_d;
  logic [6:0]         conflict_index_q, conflict_index_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  // Tag travels one stage behind the address so it lines up with the store's registered data.
  logic               tag_vld_q, tag_vld_d;
  logic               tag_self_q, tag_self_d;
  logic [6:0]         tag_peer_q, tag_peer_d;

  logic [6:0] peer;
  logic       hit;
  logic       bad_req;

  peer_addr_gen u_peer_addr_gen (
    .target (target_q),
    .k      (k_q),
    .peer   (peer)
  );

  assign bad_req = (candidate == '0) || (candidate > 4'd9) || (target_index > 7'(CELLS - 1));
  assign hit     = tag_vld_q && !tag_self_q && (mem_data_out == cand_q);

  always_comb begin
    state_d          = state_q;
    k_d              = k_q;
    target_d         = target_q;
    cand_d           = cand_q;
    conflict_d       = conflict_q;
    conflict_index_d = conflict_index_q;
    valid_d          = valid_q;
    err_d            = err_q;
    tag_vld_d        = (state_q == SCAN);
    tag_self_d       = (peer == target_q);
    tag_peer_d       = peer;

    if (hit && !conflict_q) begin
      conflict_d       = 1'b1;
      conflict_index_d = tag_peer_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          target_d         = target_index;
          cand_d           = candidate;
          k_d              = '0;
          conflict_d       = 1'b0;
          conflict_index_d = NO_CONFLICT;
          valid_d          = 1'b0;
          err_d            = bad_req;
          state_d          = bad_req ? DONE : SCAN;
        end
      end
      SCAN: begin
        k_d = k_q + 5'd1;
        if (k_q == 5'(PEER_COUNT - 1))
          state_d = DRAIN;
      end
      DRAIN: begin
        // Final compare lands on this edge, so fold it into the verdict.
        valid_d = !(conflict_q || hit);
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      k_q              <= '0;
      target_q         <= '0;
      cand_q           <= '0;
      conflict_q       <= 1'b0;
      conflict_index_q <= NO_CONFLICT;
      valid_q          <= 1'b0;
      err_q            <= 1'b0;
      tag_vld_q        <= 1'b0;
      tag_self_q       <= 1'b0;
      tag_peer_q       <= '0;
    end else begin
      state_q          <= state_d;
      k_q              <= k_d;
      target_q         <= target_d;
      cand_q           <= cand_d;
      conflict_q       <= conflict_d;
      conflict_index_q <= conflict_index_d;
      valid_q          <= valid_d;
      err_q            <= err_d;
      tag_vld_q        <= tag_vld_d;
      tag_self_q       <= tag_self_d;
      tag_peer_q       <= tag_peer_d;
    end
  end

  assign mem_read_en    = (state_q == SCAN);
  assign mem_write_en   = 1'b0;
  assign mem_cell_index = (state_q == SCAN) ? peer : 7'd0;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign valid          = valid_q;
  assign err            = err_q;
  assign conflict_index = conflict_index_q;

endmodule
